// File: rtl/move_button_serializer.sv
// Replays an accepted {x, y} move as timed logic_0/logic_1 button pulses (MSB first), then one activity pulse.
// Optional board range check on accepted moves: define MOVE_BOARD_RANGE_CHECK_EN.
module move_button_serializer #(
    parameter int COORD_BITS   = 4,
    parameter int BOARD_SIZE   = 10,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  move_valid,
    input  logic [COORD_BITS-1:0] move_x,
    input  logic [COORD_BITS-1:0] move_y,
    output logic                  move_ready,
    output logic                  logic_0_button,
    output logic                  logic_1_button,
    output logic                  activity_button,
    output logic                  busy,
    output logic                  move_error,
    output logic [9:0]            moves_sent
);

    localparam int SHIFT_W = 2 * COORD_BITS;
    localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int BIT_W   = $clog2(SHIFT_W) + 1;

    localparam logic [CNT_W-1:0] PULSE_LAST      = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST        = CNT_W'(GAP_CYCLES - 1);
    // The IDLE/acceptance cycle supplies the final low cycle of the commit gap,
    // so COMMIT_GAP itself lasts one cycle less (and is skipped when GAP_CYCLES==1).
    localparam logic [CNT_W-1:0] COMMIT_GAP_LAST = CNT_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);
    localparam logic [BIT_W-1:0] BITS_LAST       = BIT_W'(SHIFT_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        BIT_PULSE,
        BIT_GAP,
        COMMIT_PULSE,
        COMMIT_GAP
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [SHIFT_W-1:0]   shift_reg, shift_next;
    logic [BIT_W-1:0]     bits_reg, bits_next;
    logic                 reject;
    logic                 move_in_range;

    logic                 logic_0_reg, logic_0_next;
    logic                 logic_1_reg, logic_1_next;
    logic                 activity_reg, activity_next;
    logic                 busy_reg, busy_next;
    logic                 ready_reg, ready_next;
    logic                 error_reg, error_next;
    logic [9:0]           moves_sent_reg, moves_sent_next;

`ifdef MOVE_BOARD_RANGE_CHECK_EN
    localparam logic [COORD_BITS:0] BOARD_LIM = (COORD_BITS + 1)'(BOARD_SIZE);
    assign move_in_range = ({1'b0, move_x} < BOARD_LIM) && ({1'b0, move_y} < BOARD_LIM);
`else
    assign move_in_range = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            shift_reg      <= '0;
            bits_reg       <= '0;
            logic_0_reg    <= 1'b0;
            logic_1_reg    <= 1'b0;
            activity_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            ready_reg      <= 1'b1;
            error_reg      <= 1'b0;
            moves_sent_reg <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            shift_reg      <= shift_next;
            bits_reg       <= bits_next;
            logic_0_reg    <= logic_0_next;
            logic_1_reg    <= logic_1_next;
            activity_reg   <= activity_next;
            busy_reg       <= busy_next;
            ready_reg      <= ready_next;
            error_reg      <= error_next;
            moves_sent_reg <= moves_sent_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        bits_next  = bits_reg;
        reject     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (move_valid) begin
                    if (move_in_range) begin
                        state_next = BIT_PULSE;
                        shift_next = {move_x, move_y};
                        bits_next  = BITS_LAST;
                        cnt_next   = '0;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            BIT_PULSE: begin
                if (cnt_reg == PULSE_LAST) begin
                    state_next = BIT_GAP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            BIT_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next   = '0;
                    shift_next = shift_reg << 1;
                    if (bits_reg == '0) begin
                        state_next = COMMIT_PULSE;
                    end else begin
                        bits_next  = bits_reg - 1'b1;
                        state_next = BIT_PULSE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            COMMIT_PULSE: begin
                if (cnt_reg == PULSE_LAST) begin
                    cnt_next   = '0;
                    state_next = (GAP_CYCLES > 1) ? COMMIT_GAP : IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            COMMIT_GAP: begin
                if (cnt_reg == COMMIT_GAP_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered buttons line up with it.
    always_comb begin
        logic_1_next    = (state_next == BIT_PULSE) && shift_next[SHIFT_W-1];
        logic_0_next    = (state_next == BIT_PULSE) && !shift_next[SHIFT_W-1];
        activity_next   = (state_next == COMMIT_PULSE);
        busy_next       = (state_next != IDLE);
        ready_next      = (state_next == IDLE);
        error_next      = reject;
        moves_sent_next = moves_sent_reg;
        if ((state_next == COMMIT_PULSE) && (state_reg != COMMIT_PULSE)) begin
            moves_sent_next = moves_sent_reg + 10'd1;
        end
    end

    assign move_ready      = ready_reg;
    assign logic_0_button  = logic_0_reg;
    assign logic_1_button  = logic_1_reg;
    assign activity_button = activity_reg;
    assign busy            = busy_reg;
    assign move_error      = error_reg;
    assign moves_sent      = moves_sent_reg;

endmodule

// File: tb/tb_move_button_serializer.sv
// Bench for move_button_serializer: default-timing and 1/1-timing instances checked every cycle
// against a timeline model (slot = elapsed/period); honours MOVE_BOARD_RANGE_CHECK_EN.
module tb_move_button_serializer;

    logic       clk;
    logic       rst [2];
    logic       mv  [2];
    logic [3:0] mx  [2];
    logic [3:0] my  [2];
    logic       rdy [2];
    logic       l0  [2];
    logic       l1  [2];
    logic       act [2];
    logic       bsy [2];
    logic       err [2];
    logic [9:0] ms  [2];

    int vectors;
    int miscompares;

    // Reference model: t = cycles since acceptance (0 = idle), nine symbols per move.
    int t      [2];
    int sym    [2][9];
    int ms_m   [2];
    int err_m  [2];
    int acc    [2];
    int low_run[2];
    int prev_any[2];

    move_button_serializer u_dut0 (
        .clk(clk), .reset(rst[0]), .move_valid(mv[0]), .move_x(mx[0]), .move_y(my[0]),
        .move_ready(rdy[0]), .logic_0_button(l0[0]), .logic_1_button(l1[0]),
        .activity_button(act[0]), .busy(bsy[0]), .move_error(err[0]), .moves_sent(ms[0])
    );

    move_button_serializer #(.PULSE_CYCLES(1), .GAP_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(rst[1]), .move_valid(mv[1]), .move_x(mx[1]), .move_y(my[1]),
        .move_ready(rdy[1]), .logic_0_button(l0[1]), .logic_1_button(l1[1]),
        .activity_button(act[1]), .busy(bsy[1]), .move_error(err[1]), .moves_sent(ms[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pulse_len(int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int gap_len(int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int period(int d);
        return pulse_len(d) + gap_len(d);
    endfunction

    function automatic int out_of_range(int x, int y);
`ifdef MOVE_BOARD_RANGE_CHECK_EN
        return (x >= 10 || y >= 10) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // 0 none, 1 logic_0, 2 logic_1, 3 activity
    function automatic int exp_code(int d);
        int slot, ph;
        if (t[d] == 0) return 0;
        slot = (t[d] - 1) / period(d);
        ph   = (t[d] - 1) % period(d);
        return (ph < pulse_len(d)) ? sym[d][slot] : 0;
    endfunction

    function automatic int exp_ready(int d);
        return (t[d] == 0 || t[d] == 9 * period(d)) ? 1 : 0;
    endfunction

    task automatic check_val(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input int d);
        logic [7:0] b;
        acc[d] = 0;
        if (rst[d]) begin
            t[d] = 0; ms_m[d] = 0; err_m[d] = 0;
        end else begin
            err_m[d] = 0;
            if (exp_ready(d) == 1) begin
                if (mv[d]) begin
                    if (out_of_range(int'(mx[d]), int'(my[d])) != 0) begin
                        err_m[d] = 1;
                        t[d] = 0;
                    end else begin
                        b = {mx[d], my[d]};
                        for (int i = 0; i < 8; i++) sym[d][i] = b[7-i] ? 2 : 1;
                        sym[d][8] = 3;
                        t[d] = 1;
                        acc[d] = 1;
                    end
                end else begin
                    t[d] = 0;
                end
            end else begin
                t[d] = t[d] + 1;
            end
            if (t[d] > 0 && (t[d] - 1) == 8 * period(d)) ms_m[d] = (ms_m[d] + 1) % 1024;
        end
    endtask

    task automatic check_dut(input int d);
        int code, any;
        code = act[d] ? 3 : (l1[d] ? 2 : (l0[d] ? 1 : 0));
        any  = (l0[d] | l1[d] | act[d]) ? 1 : 0;
        check_val($sformatf("d%0d_onehot", d), int'(l0[d]) + int'(l1[d]) + int'(act[d]) <= 1 ? 1 : 0, 1);
        check_val($sformatf("d%0d_button", d), code, exp_code(d));
        check_val($sformatf("d%0d_ready", d), int'(rdy[d]), exp_ready(d));
        check_val($sformatf("d%0d_busy", d), int'(bsy[d]), 1 - exp_ready(d));
        check_val($sformatf("d%0d_error", d), int'(err[d]), err_m[d]);
        check_val($sformatf("d%0d_moves_sent", d), int'(ms[d]), ms_m[d]);
        if (any == 1 && prev_any[d] == 0)
            check_val($sformatf("d%0d_gap", d), (low_run[d] >= gap_len(d)) ? 1 : 0, 1);
        low_run[d]  = any ? 0 : low_run[d] + 1;
        prev_any[d] = any;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        check_dut(0);
        check_dut(1);
    endtask

    task automatic send_move(input int d, input int x, input int y);
        int n;
        mv[d] = 1'b1; mx[d] = 4'(x); my[d] = 4'(y);
        n = 0;
        do begin step(); n++; end while (acc[d] == 0 && err_m[d] == 0 && n < 500);
        if (n >= 500) check_val("send_timeout", 0, 1);
        mv[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (t[d] != 0 && n < 2000) begin step(); n++; end
        if (n >= 2000) check_val("idle_timeout", 0, 1);
    endtask

    initial begin
        int lat, cnt, n;
        vectors = 0; miscompares = 0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; mv[d] = 1'b0; mx[d] = '0; my[d] = '0;
            t[d] = 0; ms_m[d] = 0; err_m[d] = 0; acc[d] = 0;
            low_run[d] = 1000; prev_any[d] = 0;
        end
        @(negedge clk);
        repeat (3) step();
        rst[0] = 1'b0; rst[1] = 1'b0;
        step();

        // Reset during the 5th bit pulse
        send_move(0, 3, 7);
        n = 0;
        while (t[0] < 34 && n < 100) begin step(); n++; end
        check_val("in_fifth_pulse", int'(l0[0] | l1[0]), 1);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        check_val("reset_buttons", int'(l0[0] | l1[0] | act[0]), 0);
        check_val("reset_ready", int'(rdy[0]), 1);
        repeat (80) step();

        // Directed x=3, y=7 with ready latency
        send_move(0, 3, 7);
        lat = 1;
        while (!rdy[0] && lat < 200) begin step(); lat++; end
        check_val("ready_latency", lat, 72);
        check_val("single_count", int'(ms[0]), 1);
        wait_idle(0);

        // Three moves with move_valid held
        mv[0] = 1'b1; mx[0] = 4'($urandom_range(0, 9)); my[0] = 4'($urandom_range(0, 9));
        cnt = 0; n = 0;
        while (cnt < 3 && n < 1000) begin
            step(); n++;
            if (acc[0] != 0) begin
                cnt++;
                mx[0] = 4'($urandom_range(0, 9)); my[0] = 4'($urandom_range(0, 9));
            end
        end
        mv[0] = 1'b0;
        wait_idle(0);
        check_val("b2b_count", int'(ms[0]), 4);

        // Range boundary
        send_move(0, 10, 2);
`ifdef MOVE_BOARD_RANGE_CHECK_EN
        check_val("range_error", int'(err[0]), 1);
        check_val("range_ready", int'(rdy[0]), 1);
        step();
        check_val("range_error_pulse", int'(err[0]), 0);
`else
        check_val("range_no_error", int'(err[0]), 0);
        check_val("range_busy", int'(bsy[0]), 1);
`endif
        wait_idle(0);
        send_move(0, 9, 9);
        wait_idle(0);

        // Random traffic on the default instance
        for (int i = 0; i < 1500; i++) begin
            mv[0] = ($urandom_range(0, 3) != 0);
            mx[0] = 4'($urandom_range(0, 15));
            my[0] = 4'($urandom_range(0, 15));
            step();
        end
        mv[0] = 1'b0;
        wait_idle(0);

        // 1025 moves at PULSE=GAP=1 to exercise the moves_sent wrap
        mv[1] = 1'b1; mx[1] = 4'($urandom_range(0, 9)); my[1] = 4'($urandom_range(0, 9));
        cnt = 0; n = 0;
        while (cnt < 1025 && n < 25000) begin
            step(); n++;
            if (acc[1] != 0) begin
                cnt++;
                mx[1] = 4'($urandom_range(0, 9)); my[1] = 4'($urandom_range(0, 9));
            end
        end
        if (n >= 25000) check_val("wrap_timeout", 0, 1);
        mv[1] = 1'b0;
        wait_idle(1);
        check_val("wrap_final", int'(ms[1]), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
